// File: rtl/vdc_pkg.sv
// Shared constants, FSM/job enums and the CR increment decode for the VDC CPU VRAM port.
package vdc_pkg;

    localparam logic [4:0] REG_MAWR = 5'h00;
    localparam logic [4:0] REG_MARR = 5'h01;
    localparam logic [4:0] REG_VRW  = 5'h02;
    localparam logic [4:0] REG_CR   = 5'h05;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRdCap
    } vdc_state_e;

    typedef enum logic {
        JobRead,
        JobWrite
    } vdc_job_e;

    function automatic logic [15:0] inc_decode(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'd1;
            2'b01:   return 16'd32;
            2'b10:   return 16'd64;
            default: return 16'd128;
        endcase
    endfunction

endpackage

// File: rtl/vdc_vram_arb.sv
// VRAM job FSM: waits out the renderer, then issues one registered read or write.
// Build option VDC_VRAM_MIRROR_EN clears the top MA bit on every access (32K-word mirror).
module vdc_vram_arb
    import vdc_pkg::*;
#(
    parameter int unsigned VRAM_AW = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  vdc_job_e           i_job,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_data,
    input  logic               i_render_busy,
    output logic               o_busy,
    output logic               o_wr_issue,
    output logic               o_rd_cap,
    output logic [VRAM_AW-1:0] o_ma,
    output logic               o_re,
    output logic               o_we,
    output logic [15:0]        o_md_in
);

    vdc_state_e         r_state, w_state_d;
    vdc_job_e           r_job, w_job_d;
    logic [15:0]        r_addr, w_addr_d;
    logic [15:0]        r_data, w_data_d;
    logic [VRAM_AW-1:0] r_ma, w_ma_d;
    logic               r_re, w_re_d;
    logic               r_we, w_we_d;
    logic [15:0]        r_md_in, w_md_in_d;

    logic               w_issue;
    vdc_job_e           w_iss_job;
    logic [15:0]        w_iss_addr;
    logic [15:0]        w_iss_data;

    // render_busy low in a cycle grants the bus for the next cycle, which keeps re/we registered.
    // The WAIT cycle carrying the strobe then leaves WAIT on the following edge.
    always_comb begin
        w_state_d  = r_state;
        w_job_d    = r_job;
        w_addr_d   = r_addr;
        w_data_d   = r_data;
        w_ma_d     = r_ma;
        w_re_d     = 1'b0;
        w_we_d     = 1'b0;
        w_md_in_d  = r_md_in;
        w_issue    = 1'b0;
        w_iss_job  = r_job;
        w_iss_addr = r_addr;
        w_iss_data = r_data;
        o_wr_issue = 1'b0;
        o_rd_cap   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d  = StWait;
                    w_job_d    = i_job;
                    w_addr_d   = i_addr;
                    w_data_d   = i_data;
                    w_issue    = !i_render_busy;
                    w_iss_job  = i_job;
                    w_iss_addr = i_addr;
                    w_iss_data = i_data;
                end
            end
            StWait: begin
                if (r_re || r_we) begin
                    w_state_d = r_re ? StRdCap : StIdle;
                end else if (!i_render_busy) begin
                    w_issue = 1'b1;
                end
            end
            StRdCap: begin
                o_rd_cap  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        if (w_issue) begin
            w_ma_d = w_iss_addr[VRAM_AW-1:0];
`ifdef VDC_VRAM_MIRROR_EN
            w_ma_d[VRAM_AW-1] = 1'b0;
`endif
            if (w_iss_job == JobWrite) begin
                w_we_d     = 1'b1;
                w_md_in_d  = w_iss_data;
                o_wr_issue = 1'b1;
            end else begin
                w_re_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_job   <= JobRead;
            r_addr  <= '0;
            r_data  <= '0;
            r_ma    <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_md_in <= '0;
        end else begin
            r_state <= w_state_d;
            r_job   <= w_job_d;
            r_addr  <= w_addr_d;
            r_data  <= w_data_d;
            r_ma    <= w_ma_d;
            r_re    <= w_re_d;
            r_we    <= w_we_d;
            r_md_in <= w_md_in_d;
        end
    end

    assign o_busy  = (r_state != StIdle);
    assign o_ma    = r_ma;
    assign o_re    = r_re;
    assign o_we    = r_we;
    assign o_md_in = r_md_in;

    re_we_exclusive_a: assert property (@(posedge i_clk) disable iff (i_rst) !(r_re && r_we));

endmodule

// File: rtl/vdc_cpu_vram_port.sv
// HuC6270 CPU-side VRAM port: AR/MAWR/MARR/VRR/VWR/CR register file and 8-bit access decode.
// Build option VDC_VRAM_MIRROR_EN (handled in vdc_vram_arb) mirrors VRAM at 32K words.
module vdc_cpu_vram_port
    import vdc_pkg::*;
#(
    parameter int unsigned VRAM_AW = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_cs,
    input  logic               cpu_wr,
    input  logic               cpu_rd,
    input  logic [1:0]         cpu_a,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic               busy,
    input  logic               render_busy,
    output logic [VRAM_AW-1:0] MA,
    output logic               re,
    output logic               we,
    output logic [15:0]        MD_in,
    input  logic [15:0]        MD_out
);

    logic [4:0]  r_ar;
    logic [15:0] r_mawr;
    logic [15:0] r_marr;
    logic [15:0] r_vrr;
    logic [15:0] r_vwr;
    logic [7:0]  r_lo_latch;
    logic [1:0]  r_inc_sel;
    logic [7:0]  r_cpu_dout;

    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_commit;
    logic        w_prefetch;
    logic [15:0] w_word;
    logic [15:0] w_inc;
    logic [15:0] w_marr_next;
    logic        w_start;
    vdc_job_e    w_job;
    logic [15:0] w_start_addr;
    logic [15:0] w_start_data;
    logic        w_wr_issue;
    logic        w_rd_cap;

    // A write strobe masks a simultaneous read.
    assign w_wr        = cpu_cs & cpu_wr;
    assign w_rd        = cpu_cs & cpu_rd & ~cpu_wr;
    assign w_word      = {cpu_din, r_lo_latch};
    assign w_inc       = inc_decode(r_inc_sel);
    assign w_marr_next = r_marr + w_inc;
    assign w_commit    = w_wr && (cpu_a == 2'd3) && !w_busy;
    assign w_prefetch  = w_rd && (cpu_a == 2'd3) && (r_ar == REG_VRW) && !w_busy;

    always_comb begin
        w_start      = 1'b0;
        w_job        = JobRead;
        w_start_addr = r_mawr;
        w_start_data = r_vwr;
        if (w_commit) begin
            if (r_ar == REG_MARR) begin
                w_start      = 1'b1;
                w_job        = JobRead;
                w_start_addr = w_word;
            end else if (r_ar == REG_VRW) begin
                w_start      = 1'b1;
                w_job        = JobWrite;
                w_start_addr = r_mawr;
                w_start_data = w_word;
            end
        end else if (w_prefetch) begin
            w_start      = 1'b1;
            w_job        = JobRead;
            w_start_addr = w_marr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ar       <= '0;
            r_mawr     <= '0;
            r_marr     <= '0;
            r_vrr      <= '0;
            r_vwr      <= '0;
            r_lo_latch <= '0;
            r_inc_sel  <= '0;
            r_cpu_dout <= '0;
        end else begin
            if (w_wr && (cpu_a == 2'd0)) begin
                r_ar <= cpu_din[4:0];
            end
            if (w_wr && (cpu_a == 2'd2) && !w_busy) begin
                r_lo_latch <= cpu_din;
            end
            if (w_commit) begin
                case (r_ar)
                    REG_MAWR: r_mawr    <= w_word;
                    REG_MARR: r_marr    <= w_word;
                    REG_VRW:  r_vwr     <= w_word;
                    REG_CR:   r_inc_sel <= w_word[12:11];
                    default:  ;
                endcase
            end
            // Write issue never coincides with a MAWR commit: it only follows a VWR commit or busy.
            if (w_wr_issue) begin
                r_mawr <= r_mawr + w_inc;
            end
            if (w_prefetch) begin
                r_marr <= w_marr_next;
            end
            if (w_rd_cap) begin
                r_vrr <= MD_out;
            end
            if (w_rd) begin
                case (cpu_a)
                    2'd0:    r_cpu_dout <= {7'b0, w_busy};
                    2'd2:    r_cpu_dout <= (r_ar == REG_VRW) ? r_vrr[7:0] : 8'h00;
                    2'd3:    r_cpu_dout <= (r_ar == REG_VRW) ? r_vrr[15:8] : 8'h00;
                    default: r_cpu_dout <= 8'h00;
                endcase
            end
        end
    end

    vdc_vram_arb #(
        .VRAM_AW (VRAM_AW)
    ) u_arb (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_start       (w_start),
        .i_job         (w_job),
        .i_addr        (w_start_addr),
        .i_data        (w_start_data),
        .i_render_busy (render_busy),
        .o_busy        (w_busy),
        .o_wr_issue    (w_wr_issue),
        .o_rd_cap      (w_rd_cap),
        .o_ma          (MA),
        .o_re          (re),
        .o_we          (we),
        .o_md_in       (MD_in)
    );

    assign busy     = w_busy;
    assign cpu_dout = r_cpu_dout;

endmodule

// File: tb/tb_vdc_cpu_vram_port.sv
// Self-checking bench for vdc_cpu_vram_port: access table plus timing, arbitration, reset and mirror.
module tb_vdc_cpu_vram_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_cs, cpu_wr, cpu_rd;
    logic [1:0]  cpu_a;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic        render_busy;
    logic [15:0] MA;
    logic        re, we;
    logic [15:0] MD_in;
    logic [15:0] MD_out;

    logic        tb_we;
    logic [15:0] tb_addr, tb_data;
    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wq[$];
    logic [15:0] rq[$];

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [7:0]  d;
        logic [7:0]  exp;
        bit          pw;
        bit          pr;
        logic [15:0] ma;
        logic [15:0] md;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    vdc_cpu_vram_port #(
        .VRAM_AW (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_cs      (cpu_cs),
        .cpu_wr      (cpu_wr),
        .cpu_rd      (cpu_rd),
        .cpu_a       (cpu_a),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .busy        (busy),
        .render_busy (render_busy),
        .MA          (MA),
        .re          (re),
        .we          (we),
        .MD_in       (MD_in),
        .MD_out      (MD_out)
    );

    // VRAM model: synchronous, read data one cycle after re.
    always @(posedge clock) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (we) mem[MA] <= MD_in;
        if (re) MD_out <= mem[MA];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every VRAM strobe must match the oldest expected access.
    always @(negedge clock) begin
        if (!reset && (we || re)) begin
            check("re_we_exclusive", 32'(we & re), 32'h0);
            if (we) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_we: got MA=%h MD_in=%h, expected none", MA, MD_in);
                end else begin
                    check("vram_write", {MA, MD_in}, wq.pop_front());
                end
            end
            if (re) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_re: got MA=%h, expected none", MA);
                end else begin
                    check("vram_read", {16'h0, MA}, {16'h0, rq.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic vram_poke(input logic [15:0] addr, input logic [15:0] data);
        tb_we   = 1'b1;
        tb_addr = addr;
        tb_data = data;
        step();
        tb_we = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_din = d;
        step();
        cpu_cs = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_a = a;
        step();
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        d = cpu_dout;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: got busy=1 after %0d cycles, expected busy=0", n);
        end
    endtask

    function automatic vec_t v(bit wr, logic [1:0] a, logic [7:0] d, logic [7:0] exp,
                               bit pw, bit pr, logic [15:0] ma, logic [15:0] md);
        vec_t r;
        r.wr = wr; r.a = a; r.d = d; r.exp = exp;
        r.pw = pw; r.pr = pr; r.ma = ma; r.md = md;
        return r;
    endfunction

    initial begin
        #300000;
        $display("FAIL timeout: got no finish, expected finish within bound");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [15:0] mirror_ma;

        reset = 1'b1; cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_a = 2'd0; cpu_din = 8'h00; render_busy = 1'b0; tb_we = 1'b0;
        tb_addr = '0; tb_data = '0;
        step();
        vram_poke(16'h0100, 16'hBEEF);
        vram_poke(16'h0101, 16'hCAFE);
        vram_poke(16'h0300, 16'h1357);
        reset = 1'b0;

        check("rst_busy", 32'(busy), 32'h0);
        check("rst_re", 32'(re), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_ma", 32'(MA), 32'h0);
        check("rst_md_in", 32'(MD_in), 32'h0);
        check("rst_dout", 32'(cpu_dout), 32'h0);

        tbl.push_back(v(1, 0, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'h34, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h12, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 0, 8'h02, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'hCD, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'hAB, 8'h00, 1, 0, 16'h1234, 16'hABCD));
        tbl.push_back(v(1, 2, 8'h11, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h22, 8'h00, 1, 0, 16'h1235, 16'h2211));
        tbl.push_back(v(1, 0, 8'h01, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h01, 8'h00, 0, 1, 16'h0100, 16'h0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 0, 8'h02, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(0, 2, 8'h00, 8'hEF, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(0, 3, 8'h00, 8'hBE, 0, 1, 16'h0101, 16'h0));
        tbl.push_back(v(0, 2, 8'h00, 8'hFE, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(0, 3, 8'h00, 8'hCA, 0, 1, 16'h0102, 16'h0));
        tbl.push_back(v(1, 0, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(0, 2, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 0, 8'h05, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h18, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 0, 8'h00, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'hC0, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'hFF, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 0, 8'h02, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 2, 8'h55, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h66, 8'h00, 1, 0, 16'hFFC0, 16'h6655));
        tbl.push_back(v(1, 2, 8'h77, 8'h00, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 3, 8'h88, 8'h00, 1, 0, 16'h0040, 16'h8877));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pw) wq.push_back({tbl[i].ma, tbl[i].md});
            if (tbl[i].pr) rq.push_back(tbl[i].ma);
            if (tbl[i].wr) begin
                cpu_write(tbl[i].a, tbl[i].d);
            end else begin
                cpu_read(tbl[i].a, d);
                check($sformatf("tbl%0d_rd", i), 32'(d), 32'(tbl[i].exp));
            end
            wait_idle();
        end

        // Write timing: CR back to +1, MAWR=0x0200.
        cpu_write(2'd0, 8'h05); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h00);
        cpu_write(2'd0, 8'h00); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h02);
        cpu_write(2'd0, 8'h02); cpu_write(2'd2, 8'h5A);
        wq.push_back({16'h0200, 16'hA55A});
        cpu_write(2'd3, 8'hA5);
        check("wr_t1_busy", 32'(busy), 32'h1);
        check("wr_t1_we", 32'(we), 32'h1);
        step();
        check("wr_t2_busy", 32'(busy), 32'h0);
        check("wr_t2_we", 32'(we), 32'h0);

        // Read timing.
        cpu_write(2'd0, 8'h01); cpu_write(2'd2, 8'h00);
        rq.push_back(16'h0100);
        cpu_write(2'd3, 8'h01);
        check("rd_t1_busy", 32'(busy), 32'h1);
        check("rd_t1_re", 32'(re), 32'h1);
        step();
        check("rd_t2_busy", 32'(busy), 32'h1);
        check("rd_t2_re", 32'(re), 32'h0);
        step();
        check("rd_t3_busy", 32'(busy), 32'h0);
        cpu_write(2'd0, 8'h02);
        cpu_read(2'd2, d);
        check("rd_vrr_lo", 32'(d), 32'hEF);

        // Simultaneous write and read: only the AR write happens, cpu_dout holds.
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_a = 2'd0; cpu_din = 8'h02;
        step();
        cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        check("wr_rd_dout_hold", 32'(cpu_dout), 32'hEF);

        // Arbitration: render_busy high through the commit and five cycles after it.
        render_busy = 1'b1;
        cpu_write(2'd2, 8'h11);
        wq.push_back({16'h0201, 16'h2211});
        cpu_write(2'd3, 8'h22);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("arb_c%0d_busy", i + 1), 32'(busy), 32'h1);
            check($sformatf("arb_c%0d_we", i + 1), 32'(we), 32'h0);
            if (i == 2) begin
                cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a = 2'd2; cpu_din = 8'h77;
            end
            step();
            cpu_cs = 1'b0; cpu_wr = 1'b0;
        end
        render_busy = 1'b0;
        check("arb_fall_busy", 32'(busy), 32'h1);
        check("arb_fall_we", 32'(we), 32'h0);
        step();
        check("arb_fire_we", 32'(we), 32'h1);
        wait_idle();
        wq.push_back({16'h0202, 16'h3311});
        cpu_write(2'd3, 8'h33);
        wait_idle();

        // Reset while the job waits in WAIT.
        cpu_write(2'd0, 8'h00); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h03);
        cpu_write(2'd0, 8'h02);
        render_busy = 1'b1;
        cpu_write(2'd2, 8'h24);
        cpu_write(2'd3, 8'h68);
        check("rstmid_pre_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        render_busy = 1'b0;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_we", 32'(we), 32'h0);
        check("rstmid_re", 32'(re), 32'h0);
        check("rstmid_ma", 32'(MA), 32'h0);
        check("rstmid_md_in", 32'(MD_in), 32'h0);
        check("rstmid_dout", 32'(cpu_dout), 32'h0);
        step();
        step();
        check("rstmid_vram", 32'(mem[16'h0300]), 32'h1357);
        cpu_read(2'd0, d);
        check("rstmid_status", 32'(d), 32'h0);
        cpu_write(2'd0, 8'h02);
        cpu_read(2'd2, d);
        check("rstmid_vrr_lo", 32'(d), 32'h0);
        rq.push_back(16'h0001);
        cpu_read(2'd3, d);
        check("rstmid_vrr_hi", 32'(d), 32'h0);
        wait_idle();

        // Mirror behaviour on a write to MAWR=0x8005.
`ifdef VDC_VRAM_MIRROR_EN
        mirror_ma = 16'h0005;
`else
        mirror_ma = 16'h8005;
`endif
        cpu_write(2'd0, 8'h00); cpu_write(2'd2, 8'h05); cpu_write(2'd3, 8'h80);
        cpu_write(2'd0, 8'h02); cpu_write(2'd2, 8'h21);
        wq.push_back({mirror_ma, 16'h4321});
        cpu_write(2'd3, 8'h43);
        wait_idle();
        step();

        check("wq_drained", 32'(wq.size()), 32'h0);
        check("rq_drained", 32'(rq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
